// File: rtl/cfg_xbar_pkg.sv
// Shared types and size helpers for the scan-loaded LUT-tile input crossbar.
package cfg_xbar_pkg;

  typedef enum logic [1:0] {StEmpty, StLoad, StFull} cfg_state_t;

  function automatic int unsigned cfg_clog2(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned n_out, input int unsigned sel_w);
    return n_out * sel_w;
  endfunction

endpackage

// File: rtl/cfg_xbar_mux.sv
// Single N_IN:1 select; selects at or beyond N_IN read as zero.
module cfg_xbar_mux #(
  parameter int unsigned N_IN  = 31,
  parameter int unsigned SEL_W = 5
) (
  input  logic [N_IN-1:0]  data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             data_o
);

  always_comb begin
    data_o = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel_i == SEL_W'(i)) data_o = data_i[i];
    end
  end

endmodule

// File: rtl/cfg_xbar_sc.sv
// Crossbar whose select fields are scan-loaded into a shadow chain and committed atomically.
// Define CFG_XBAR_READBACK_EN to expose the chain tail on cfg_shift_out.
module cfg_xbar_sc
  import cfg_xbar_pkg::*;
#(
  parameter int unsigned N_IN    = 31,
  parameter int unsigned N_OUT   = 42,
  parameter int unsigned SEL_W   = cfg_clog2(N_IN),
  parameter int unsigned REG_OUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IN-1:0]  io_xbar_in,
  output logic [N_OUT-1:0] io_xbar_out,
  input  logic             cfg_shift_en,
  input  logic             cfg_shift_in,
  input  logic             cfg_commit,
  output logic             cfg_full,
  output logic             cfg_valid,
  output logic             cfg_err
`ifdef CFG_XBAR_READBACK_EN
  ,
  output logic             cfg_shift_out
`endif
);

  localparam int unsigned     CfgBits = cfg_bits(N_OUT, SEL_W);
  localparam int unsigned     CntW    = cfg_clog2(CfgBits + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(CfgBits);

  logic [CfgBits-1:0] shadow_q, shadow_d;
  logic [CfgBits-1:0] active_q, active_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  cfg_state_t         state_q, state_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               commit_ok, commit_rej;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= StEmpty;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (cfg_shift_en) state_d = (CfgBits == 1) ? StFull : StLoad;
      StLoad:  if (cfg_shift_en && (cnt_q == CntMax - 1'b1)) state_d = StFull;
      StFull:  if (commit_ok) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // FSM outputs
  always_comb begin
    cfg_full   = (state_q == StFull);
    commit_ok  = cfg_commit && (state_q == StFull) && !cfg_shift_en;
    commit_rej = cfg_commit && !commit_ok;
  end

  // Scan chain, bit counter and active config; a rejected commit still lets the shift happen.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = err_q | commit_rej;
    if (cfg_shift_en) begin
      shadow_d = {cfg_shift_in, shadow_q[CfgBits-1:1]};
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end
    if (commit_ok) begin
      active_d = shadow_q;
      cnt_d    = '0;
      valid_d  = 1'b1;
    end
  end

  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  logic [N_OUT-1:0] mux_out;
  logic [N_OUT-1:0] xbar_d;

  for (genvar j = 0; j < N_OUT; j++) begin : g_mux
    cfg_xbar_mux #(
      .N_IN (N_IN),
      .SEL_W(SEL_W)
    ) u_mux (
      .data_i(io_xbar_in),
      .sel_i (active_q[j*SEL_W +: SEL_W]),
      .data_o(mux_out[j])
    );
  end

  // Nothing is routed until a config has actually been committed.
  assign xbar_d = valid_q ? mux_out : '0;

  if (REG_OUT != 0) begin : g_reg_out
    logic [N_OUT-1:0] out_q;
    always_ff @(posedge clk) begin
      if (!reset) out_q <= '0;
      else        out_q <= xbar_d;
    end
    assign io_xbar_out = out_q;
  end else begin : g_comb_out
    assign io_xbar_out = xbar_d;
  end

`ifdef CFG_XBAR_READBACK_EN
  assign cfg_shift_out = shadow_q[0];
`endif

endmodule

// File: tb/tb_cfg_xbar_sc.sv
// Randomised bench for cfg_xbar_sc: combinational and registered-output instances against a
// bit-queue reference model of the scan chain and config rules.
module tb_cfg_xbar_sc;

  localparam int N_IN     = 31;
  localparam int N_OUT    = 42;
  localparam int SEL_W    = 5;
  localparam int CFG_BITS = N_OUT * SEL_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IN-1:0]   xin;
  logic              en, bin, cm;
  logic [N_OUT-1:0]  out0, out1;
  logic              full0, valid0, err0, full1, valid1, err1;
`ifdef CFG_XBAR_READBACK_EN
  logic              so0, so1;
`endif

  always #5 clk = ~clk;

  cfg_xbar_sc #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .SEL_W  (SEL_W),
    .REG_OUT(0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_xbar_in  (xin),
    .io_xbar_out (out0),
    .cfg_shift_en(en),
    .cfg_shift_in(bin),
    .cfg_commit  (cm),
    .cfg_full    (full0),
    .cfg_valid   (valid0),
    .cfg_err     (err0)
`ifdef CFG_XBAR_READBACK_EN
    ,
    .cfg_shift_out(so0)
`endif
  );

  cfg_xbar_sc #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .SEL_W  (SEL_W),
    .REG_OUT(1)
  ) dut_r (
    .clk         (clk),
    .reset       (reset),
    .io_xbar_in  (xin),
    .io_xbar_out (out1),
    .cfg_shift_en(en),
    .cfg_shift_in(bin),
    .cfg_commit  (cm),
    .cfg_full    (full1),
    .cfg_valid   (valid1),
    .cfg_err     (err1)
`ifdef CFG_XBAR_READBACK_EN
    ,
    .cfg_shift_out(so1)
`endif
  );

  // Reference model: shadow as a queue of bits (index 0 = oldest = next to fall out).
  bit               sh[$];
  int               m_cnt;
  bit               m_valid, m_err;
  int               m_sel[N_OUT];
  logic [N_OUT-1:0] exp_reg;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  function automatic logic [N_OUT-1:0] model_out(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r = '0;
    if (m_valid)
      for (int j = 0; j < N_OUT; j++)
        if (m_sel[j] < N_IN) r[j] = x[m_sel[j]];
    return r;
  endfunction

  // Independent routing of a whole config vector, used for explicit spot checks.
  function automatic logic [N_OUT-1:0] vec_out(input logic [CFG_BITS-1:0] v,
                                               input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      int s = int'(v[j*SEL_W +: SEL_W]);
      if (s < N_IN) r[j] = x[s];
    end
    return r;
  endfunction

  function automatic void model_edge(input bit rst_n, input bit sen, input bit sb, input bit com);
    if (!rst_n) begin
      sh.delete();
      repeat (CFG_BITS) sh.push_back(1'b0);
      m_cnt   = 0;
      m_valid = 0;
      m_err   = 0;
      foreach (m_sel[j]) m_sel[j] = 0;
      exp_reg = '0;
    end else begin
      exp_reg = model_out(xin);
      if (com && m_cnt == CFG_BITS && !sen) begin
        for (int j = 0; j < N_OUT; j++) begin
          int s = 0;
          for (int k = 0; k < SEL_W; k++) s += int'(sh[j*SEL_W+k]) << k;
          m_sel[j] = s;
        end
        m_valid = 1;
        m_cnt   = 0;
      end else if (com) begin
        m_err = 1;
      end
      if (sen) begin
        void'(sh.pop_front());
        sh.push_back(sb);
        if (m_cnt < CFG_BITS) m_cnt++;
      end
    end
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s [%s] @%0t: got %0h expected %0h", tag, phase, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    bit f = (m_cnt == CFG_BITS);
    check_eq("out_comb", 64'(out0), 64'(model_out(xin)));
    check_eq("out_reg", 64'(out1), 64'(exp_reg));
    check_eq("full", 64'({full0, full1}), 64'({f, f}));
    check_eq("valid", 64'({valid0, valid1}), 64'({m_valid, m_valid}));
    check_eq("err", 64'({err0, err1}), 64'({m_err, m_err}));
`ifdef CFG_XBAR_READBACK_EN
    check_eq("shift_out", 64'({so0, so1}), 64'({sh[0], sh[0]}));
`endif
  endtask

  task automatic cycle(input bit rst_n, input bit sen, input bit sb, input bit com);
    reset = rst_n;
    en    = sen;
    bin   = sb;
    cm    = com;
    @(posedge clk);
    model_edge(rst_n, sen, sb, com);
    #1;
    compare_all();
  endtask

  task automatic load_vec(input logic [CFG_BITS-1:0] v);
    for (int i = 0; i < CFG_BITS; i++) cycle(1'b1, 1'b1, v[i], 1'b0);
  endtask

  task automatic rand_vec(output logic [CFG_BITS-1:0] v);
    for (int i = 0; i < CFG_BITS; i++) v[i] = 1'($urandom);
  endtask

  logic [CFG_BITS-1:0] vid, v2, v3, vs;
  logic [N_OUT-1:0]    exp_id;
  logic [N_IN-1:0]     pat;
  bit                  bx;

  initial begin
    xin = '0; en = 0; bin = 0; cm = 0; reset = 0;

    phase = "reset";
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_out", 64'({out0, out1}), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Identity pattern: field j = j mod 31
    phase = "identity";
    for (int j = 0; j < N_OUT; j++) vid[j*SEL_W +: SEL_W] = SEL_W'(j % 31);
    pat = 31'h5A5A_1234;
    xin = pat;
    load_vec(vid);
    check_eq("full_before_commit", 64'(full0), 64'd1);
    for (int j = 0; j < N_OUT; j++) exp_id[j] = pat[j % 31];
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("id_comb_now", 64'(out0), 64'(exp_id));
    check_eq("id_reg_lag", 64'(out1), 64'd0);
    check_eq("valid_after", 64'(valid0), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("id_reg_next", 64'(out1), 64'(exp_id));
    for (int i = 0; i < 20; i++) begin
      xin = N_IN'($urandom);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Early commit is rejected and counting continues from 100
    phase = "early_commit";
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rand_vec(v2);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, v2[i], 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("early_err", 64'(err0), 64'd1);
    check_eq("early_valid", 64'(valid0), 64'd0);
    check_eq("early_out", 64'(out0), 64'd0);
    for (int i = 100; i < CFG_BITS - 1; i++) cycle(1'b1, 1'b1, v2[i], 1'b0);
    check_eq("early_not_full", 64'(full0), 64'd0);
    cycle(1'b1, 1'b1, v2[CFG_BITS-1], 1'b0);
    check_eq("early_full", 64'(full0), 64'd1);

    // Commit together with a shift while full
    phase = "commit_shift";
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    xin = N_IN'($urandom);
    load_vec(v2);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("cs_first_ok", 64'(out0), 64'(vec_out(v2, xin)));
    rand_vec(v3);
    load_vec(v3);
    bx = 1'($urandom);
    cycle(1'b1, 1'b1, bx, 1'b1);
    check_eq("cs_err", 64'(err0), 64'd1);
    check_eq("cs_active_kept", 64'(out0), 64'(vec_out(v2, xin)));
    check_eq("cs_still_full", 64'(full0), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    vs = {bx, v3[CFG_BITS-1:1]};
    check_eq("cs_shifted_commit", 64'(out0), 64'(vec_out(vs, xin)));

    // All selects out of range
    phase = "out_of_range";
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    xin = '1;
    load_vec('1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("oor_out", 64'({out0, out1}), 64'd0);
    check_eq("oor_valid", 64'(valid0), 64'd1);

    // Reset part-way through a load after a good commit
    phase = "reset_mid_load";
    xin = pat;
    load_vec(vid);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, 1'($urandom), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rml_all_zero", 64'({out0, out1, valid0, err0, full0}), 64'd0);
    rand_vec(v2);
    load_vec(v2);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("rml_reload", 64'(out0), 64'(vec_out(v2, xin)));

    // Random traffic
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      xin = N_IN'($urandom);
      cycle(($urandom_range(0, 299) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 19) == 0));
    end

    // Scan-out of an over-shifted pattern
    phase = "readback";
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rand_vec(v2);
    load_vec(v2);
    load_vec('0);
    check_eq("rb_full", 64'(full0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
